// File: rtl/store_commit_buffer.sv
// Post-retire store buffer: in-order drain to memory over a req/resp handshake,
// with youngest-match word-address forwarding for younger loads.
module store_commit_buffer #(
    parameter int unsigned N     = 3,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [N-1:0]                 enq_valid,
    input  logic [N-1:0][31:0]           enq_addr,
    input  logic [N-1:0][31:0]           enq_data,
    input  logic [N-1:0][1:0]            enq_size,
    output logic [$clog2(DEPTH+1)-1:0]   free_slots,
    output logic                         empty,
    output logic                         overflow,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [31:0]                  mem_req_addr,
    output logic [31:0]                  mem_req_data,
    output logic [3:0]                   mem_req_be,
    input  logic                         mem_resp_valid,
    input  logic [31:0]                  ld_addr,
    output logic                         ld_hit,
    output logic [31:0]                  ld_data,
    output logic [3:0]                   ld_be
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;
    state_t state_q, state_n;

    logic [PTR_W-1:0] head_q, head_n, tail_q, tail_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [DEPTH-1:0] valid_q, valid_n;
    logic [29:0]      ent_addr_q [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [3:0]       ent_be_q   [DEPTH];

    logic [3:0]       lane_be   [N];
    logic [31:0]      lane_data [N];
    logic [PTR_W-1:0] wr_idx    [N];
    logic [CNT_W-1:0] lead, vcnt, accepted;
    logic             run, pop;
    logic [31:0]      req_addr_n, req_data_n;
    logic [3:0]       req_be_n;
    logic [PTR_W-1:0] fwd_idx;
    logic             unused_ld_lsb;

    assign unused_ld_lsb = ^ld_addr[1:0];

    // Byte-lane placement of each incoming store
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            lane_be[i]   = 4'b1111;
            lane_data[i] = enq_data[i];
            unique case (enq_size[i])
                2'd0: begin
                    lane_be[i]   = 4'b0001 << enq_addr[i][1:0];
                    lane_data[i] = enq_data[i] << {enq_addr[i][1:0], 3'b000};
                end
                2'd1: begin
                    lane_be[i]   = 4'b0011 << {enq_addr[i][1], 1'b0};
                    lane_data[i] = enq_data[i] << {enq_addr[i][1], 4'b0000};
                end
                default: ;
            endcase
        end
    end

    // Only the leading contiguous run of valid lanes is eligible, capped by free space
    always_comb begin
        lead = '0;
        vcnt = '0;
        run  = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            wr_idx[i] = tail_q + PTR_W'(i);
            if (enq_valid[i]) begin
                vcnt = vcnt + CNT_W'(1);
                if (run) lead = lead + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        accepted = (lead > free_slots) ? free_slots : lead;
    end

    // Drain FSM next state plus queue bookkeeping
    always_comb begin
        state_n    = state_q;
        head_n     = head_q;
        valid_n    = valid_q;
        pop        = 1'b0;
        req_addr_n = mem_req_addr;
        req_data_n = mem_req_data;
        req_be_n   = mem_req_be;
        unique case (state_q)
            S_IDLE:  if (count_q != '0) state_n = S_REQ;
            S_REQ:   if (mem_req_ready) state_n = S_WAIT;
            S_WAIT:  if (mem_resp_valid) pop = 1'b1;
            default: state_n = S_IDLE;
        endcase
        if (pop) begin
            valid_n[head_q] = 1'b0;
            head_n          = head_q + PTR_W'(1);
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (CNT_W'(i) < accepted) valid_n[wr_idx[i]] = 1'b1;
        end
        tail_n  = tail_q + PTR_W'(accepted);
        count_n = count_q + accepted - CNT_W'(pop);
        if (pop) state_n = (count_n != '0) ? S_REQ : S_IDLE;
        // New head may be the store being written this very cycle
        if (state_n == S_REQ && state_q != S_REQ) begin
            req_addr_n = {ent_addr_q[head_n], 2'b00};
            req_data_n = ent_data_q[head_n];
            req_be_n   = ent_be_q[head_n];
            for (int unsigned i = 0; i < N; i++) begin
                if (CNT_W'(i) < accepted && wr_idx[i] == head_n) begin
                    req_addr_n = {enq_addr[i][31:2], 2'b00};
                    req_data_n = lane_data[i];
                    req_be_n   = lane_be[i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_n;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            free_slots    <= CNT_W'(DEPTH);
            empty         <= 1'b1;
            overflow      <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_req_be    <= '0;
        end else begin
            head_q        <= head_n;
            tail_q        <= tail_n;
            count_q       <= count_n;
            valid_q       <= valid_n;
            free_slots    <= CNT_W'(DEPTH) - count_n;
            empty         <= (count_n == '0) && (state_n == S_IDLE);
            overflow      <= overflow | (vcnt > accepted);
            mem_req_valid <= (state_n == S_REQ);
            mem_req_addr  <= req_addr_n;
            mem_req_data  <= req_data_n;
            mem_req_be    <= req_be_n;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < N; i++) begin
            if (CNT_W'(i) < accepted) begin
                ent_addr_q[wr_idx[i]] <= enq_addr[i][31:2];
                ent_data_q[wr_idx[i]] <= lane_data[i];
                ent_be_q[wr_idx[i]]   <= lane_be[i];
            end
        end
    end

    // Walk oldest to youngest so the youngest match is left standing
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        ld_be   = '0;
        fwd_idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if (valid_q[fwd_idx] && ent_addr_q[fwd_idx] == ld_addr[31:2]) begin
                ld_hit  = 1'b1;
                ld_data = ent_data_q[fwd_idx];
                ld_be   = ent_be_q[fwd_idx];
            end
        end
    end
endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: byte-lane vector table, directed corner
// sequences, and a random run against a queue-based reference model.
module tb_store_commit_buffer;
    logic              clock = 1'b0;
    logic              reset_n;
    logic [2:0]        enq_valid;
    logic [2:0][31:0]  enq_addr;
    logic [2:0][31:0]  enq_data;
    logic [2:0][1:0]   enq_size;
    logic [3:0]        free_slots;
    logic              empty, overflow, mem_req_valid, mem_req_ready;
    logic [31:0]       mem_req_addr, mem_req_data;
    logic [3:0]        mem_req_be;
    logic              mem_resp_valid;
    logic [31:0]       ld_addr;
    logic              ld_hit;
    logic [31:0]       ld_data;
    logic [3:0]        ld_be;

    store_commit_buffer #(.N(3), .DEPTH(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_size(enq_size),
        .free_slots(free_slots), .empty(empty), .overflow(overflow),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_be(mem_req_be),
        .mem_resp_valid(mem_resp_valid),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_be(ld_be)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    int   total = 0;
    int   bad   = 0;
    vec_t vt [7];
    ent_t q [$];
    int   prev_size, lat, lead, pc, acc, r;
    bit   outst, ov_m, exp_v, pop_m, hs, run, hit_m;
    logic [31:0] d_m;
    logic [3:0]  be_m;
    logic [1:0]  sz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_enq();
        enq_valid = '0;
        enq_addr  = '0;
        enq_data  = '0;
        enq_size  = '0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        enq_valid[l] = 1'b1;
        enq_addr[l]  = a;
        enq_data[l]  = d;
        enq_size[l]  = s;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        ld_addr        = '0;
        clear_enq();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    function automatic ent_t mk_ent(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        ent_t e;
        int   sh;
        e.addr = {a[31:2], 2'b00};
        case (s)
            2'd0: begin sh = 8 * int'(a[1:0]); e.be = 4'b0001 << a[1:0]; end
            2'd1: begin sh = a[1] ? 16 : 0;    e.be = a[1] ? 4'b1100 : 4'b0011; end
            default: begin sh = 0;             e.be = 4'b1111; end
        endcase
        e.data = d << sh;
        return e;
    endfunction

    initial begin
        vt[0] = '{32'h0000_2001, 32'h0000_005A, 2'd0, 32'h0000_2000, 32'h0000_5A00, 4'b0010};
        vt[1] = '{32'h0000_3003, 32'h0000_00AB, 2'd0, 32'h0000_3000, 32'hAB00_0000, 4'b1000};
        vt[2] = '{32'h0000_4002, 32'h0000_1234, 2'd1, 32'h0000_4000, 32'h1234_0000, 4'b1100};
        vt[3] = '{32'h0000_4000, 32'h0000_BEEF, 2'd1, 32'h0000_4000, 32'h0000_BEEF, 4'b0011};
        vt[4] = '{32'h0000_5003, 32'h0000_1234, 2'd1, 32'h0000_5000, 32'h1234_0000, 4'b1100};
        vt[5] = '{32'h0000_6005, 32'hCAFE_F00D, 2'd2, 32'h0000_6004, 32'hCAFE_F00D, 4'b1111};
        vt[6] = '{32'h0000_7002, 32'h1122_3344, 2'd3, 32'h0000_7000, 32'h1122_3344, 4'b1111};

        do_reset();
        chk("rst_free", 32'(free_slots), 32'd8);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        chk("rst_req_data", mem_req_data, 32'd0);
        chk("rst_req_be", 32'(mem_req_be), 32'd0);
        chk("rst_ld_hit", 32'(ld_hit), 32'd0);

        // single word store with a two-cycle response
        set_lane(0, 32'h1000, 32'hDEADBEEF, 2'd2);
        mem_req_ready = 1'b1;
        @(negedge clock);
        clear_enq();
        chk("t1_empty_T", 32'(empty), 32'd0);
        chk("t1_free_T", 32'(free_slots), 32'd7);
        chk("t1_valid_T", 32'(mem_req_valid), 32'd0);
        @(negedge clock);
        chk("t1_valid_T1", 32'(mem_req_valid), 32'd1);
        chk("t1_addr", mem_req_addr, 32'h1000);
        chk("t1_be", 32'(mem_req_be), 32'hF);
        chk("t1_data", mem_req_data, 32'hDEADBEEF);
        @(negedge clock);
        mem_req_ready = 1'b0;
        chk("t1_valid_wait", 32'(mem_req_valid), 32'd0);
        @(negedge clock);
        chk("t1_empty_wait", 32'(empty), 32'd0);
        mem_resp_valid = 1'b1;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        chk("t1_empty_after", 32'(empty), 32'd1);
        chk("t1_free_after", 32'(free_slots), 32'd8);

        // byte-lane placement table
        for (int i = 0; i < 7; i++) begin
            set_lane(0, vt[i].addr, vt[i].data, vt[i].size);
            @(negedge clock);
            clear_enq();
            @(negedge clock);
            chk($sformatf("vec%0d_valid", i), 32'(mem_req_valid), 32'd1);
            chk($sformatf("vec%0d_addr", i), mem_req_addr, vt[i].exp_addr);
            chk($sformatf("vec%0d_data", i), mem_req_data, vt[i].exp_data);
            chk($sformatf("vec%0d_be", i), 32'(mem_req_be), 32'(vt[i].exp_be));
            ld_addr = vt[i].exp_addr + 32'd3;
            #1;
            chk($sformatf("vec%0d_ld_hit", i), 32'(ld_hit), 32'd1);
            chk($sformatf("vec%0d_ld_data", i), ld_data, vt[i].exp_data);
            chk($sformatf("vec%0d_ld_be", i), 32'(ld_be), 32'(vt[i].exp_be));
            mem_req_ready = 1'b1;
            @(negedge clock);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            @(negedge clock);
            mem_resp_valid = 1'b0;
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'd1);
            chk($sformatf("vec%0d_ld_gone", i), 32'(ld_hit), 32'd0);
        end

        // fill past capacity with memory stalled
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) set_lane(j, 32'h100 + 32'(4 * (3 * k + j)), 32'(3 * k + j), 2'd2);
            @(negedge clock);
            clear_enq();
            chk($sformatf("t2_free_%0d", k), 32'(free_slots), (k == 0) ? 32'd5 : (k == 1) ? 32'd2 : 32'd0);
        end
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_valid", 32'(mem_req_valid), 32'd1);
        chk("t2_addr", mem_req_addr, 32'h100);
        set_lane(0, 32'h200, 32'h55, 2'd2);
        @(negedge clock);
        clear_enq();
        chk("t2_free_full", 32'(free_slots), 32'd0);
        chk("t2_addr_held", mem_req_addr, 32'h100);
        chk("t2_data_held", mem_req_data, 32'd0);
        ld_addr = 32'h11C;
        #1;
        chk("t2_ld_last_hit", 32'(ld_hit), 32'd1);
        chk("t2_ld_last_data", ld_data, 32'd7);
        ld_addr = 32'h120;
        #1;
        chk("t2_ld_dropped", 32'(ld_hit), 32'd0);

        // youngest-match forwarding
        do_reset();
        set_lane(0, 32'h2003, 32'hAB, 2'd0);
        @(negedge clock);
        clear_enq();
        ld_addr = 32'h2000;
        #1;
        chk("t3_old_be", 32'(ld_be), 32'b1000);
        chk("t3_old_data", ld_data, 32'hAB00_0000);
        set_lane(0, 32'h2002, 32'h1234, 2'd1);
        @(negedge clock);
        clear_enq();
        #1;
        chk("t3_hit", 32'(ld_hit), 32'd1);
        chk("t3_be", 32'(ld_be), 32'b1100);
        chk("t3_data", ld_data, 32'h1234_0000);
        ld_addr = 32'h2004;
        #1;
        chk("t3_miss_hit", 32'(ld_hit), 32'd0);
        chk("t3_miss_data", ld_data, 32'd0);
        chk("t3_miss_be", 32'(ld_be), 32'd0);

        // enqueue two lanes in the pop cycle with one free slot
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < ((k == 2) ? 1 : 3); j++) set_lane(j, 32'h300 + 32'(4 * (3 * k + j)), 32'(3 * k + j), 2'd2);
            @(negedge clock);
            clear_enq();
        end
        chk("t5_free1", 32'(free_slots), 32'd1);
        chk("t5_ovf0", 32'(overflow), 32'd0);
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        chk("t5_wait", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b1;
        set_lane(0, 32'h400, 32'h77, 2'd2);
        set_lane(1, 32'h404, 32'h88, 2'd2);
        @(negedge clock);
        mem_resp_valid = 1'b0;
        clear_enq();
        chk("t5_free", 32'(free_slots), 32'd1);
        chk("t5_ovf", 32'(overflow), 32'd1);
        chk("t5_valid", 32'(mem_req_valid), 32'd1);
        chk("t5_addr", mem_req_addr, 32'h304);
        ld_addr = 32'h400;
        #1;
        chk("t5_ld_acc", 32'(ld_hit), 32'd1);
        ld_addr = 32'h404;
        #1;
        chk("t5_ld_drop", 32'(ld_hit), 32'd0);

        // asynchronous reset while a write is outstanding
        do_reset();
        for (int j = 0; j < 3; j++) set_lane(j, 32'h500 + 32'(4 * j), 32'(j), 2'd2);
        @(negedge clock);
        clear_enq();
        set_lane(0, 32'h50C, 32'h3, 2'd2);
        @(negedge clock);
        clear_enq();
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        chk("t6_wait", 32'(mem_req_valid), 32'd0);
        chk("t6_free4", 32'(free_slots), 32'd4);
        ld_addr = 32'h500;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_free", 32'(free_slots), 32'd8);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_ovf", 32'(overflow), 32'd0);
        chk("t6_valid", 32'(mem_req_valid), 32'd0);
        chk("t6_addr", mem_req_addr, 32'd0);
        chk("t6_be", 32'(mem_req_be), 32'd0);
        chk("t6_ld", 32'(ld_hit), 32'd0);
        @(negedge clock);
        reset_n        = 1'b1;
        mem_resp_valid = 1'b1;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        chk("t6_post_free", 32'(free_slots), 32'd8);
        chk("t6_post_valid", 32'(mem_req_valid), 32'd0);
        @(negedge clock);
        chk("t6_post_valid2", 32'(mem_req_valid), 32'd0);

        // random traffic against the queue model
        do_reset();
        q.delete();
        outst     = 1'b0;
        ov_m      = 1'b0;
        prev_size = 0;
        lat       = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ld_addr = 32'h8000 + 32'($urandom_range(0, 9) << 2) + 32'($urandom_range(0, 3));
            #1;
            hit_m = 1'b0;
            d_m   = '0;
            be_m  = '0;
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (q[k].addr[31:2] == ld_addr[31:2]) begin
                    hit_m = 1'b1;
                    d_m   = q[k].data;
                    be_m  = q[k].be;
                    break;
                end
            end
            chk("rnd_ld_hit", 32'(ld_hit), 32'(hit_m));
            chk("rnd_ld_data", ld_data, d_m);
            chk("rnd_ld_be", 32'(ld_be), 32'(be_m));
            chk("rnd_free", 32'(free_slots), 32'(8 - q.size()));
            chk("rnd_empty", 32'(empty), 32'(q.size() == 0));
            chk("rnd_ovf", 32'(overflow), 32'(ov_m));
            exp_v = (q.size() != 0) && !outst && (prev_size != 0);
            chk("rnd_req_valid", 32'(mem_req_valid), 32'(exp_v));
            if (exp_v) begin
                chk("rnd_req_addr", mem_req_addr, q[0].addr);
                chk("rnd_req_data", mem_req_data, q[0].data);
                chk("rnd_req_be", 32'(mem_req_be), 32'(q[0].be));
            end

            mem_req_ready = ($urandom_range(0, 2) != 0);
            pop_m = 1'b0;
            if (outst) begin
                mem_resp_valid = (lat == 0);
                pop_m          = (lat == 0);
                if (lat != 0) lat--;
            end else begin
                mem_resp_valid = ($urandom_range(0, 7) == 0);
            end
            r = int'($urandom_range(0, 9));
            if (r < 5)      enq_valid = 3'b000;
            else if (r < 7) enq_valid = 3'b001;
            else if (r < 8) enq_valid = 3'b011;
            else if (r < 9) enq_valid = 3'b111;
            else            enq_valid = 3'($urandom_range(0, 7));
            for (int l = 0; l < 3; l++) begin
                sz          = 2'($urandom_range(0, 3));
                enq_size[l] = sz;
                enq_addr[l] = 32'h8000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
                enq_data[l] = (sz == 2'd0) ? 32'($urandom_range(0, 255)) :
                              (sz == 2'd1) ? 32'($urandom_range(0, 65535)) : $urandom;
            end

            lead = 0;
            pc   = 0;
            run  = 1'b1;
            for (int l = 0; l < 3; l++) begin
                if (enq_valid[l]) begin
                    pc++;
                    if (run) lead++;
                end else begin
                    run = 1'b0;
                end
            end
            acc = (lead < 8 - q.size()) ? lead : 8 - q.size();
            if (pc > acc) ov_m = 1'b1;
            hs        = exp_v && mem_req_ready;
            prev_size = q.size();
            if (pop_m) begin
                void'(q.pop_front());
                outst = 1'b0;
            end
            if (hs) begin
                outst = 1'b1;
                lat   = int'($urandom_range(0, 3));
            end
            for (int l = 0; l < acc; l++) q.push_back(mk_ent(enq_addr[l], enq_data[l], enq_size[l]));
            @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
